// File: rtl/id_ex_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths and the
// bit layout of the packed control bundle.
package id_ex_reg_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int CTRL_W_DEF = 14;
  localparam int CNT_W_DEF  = 16;

  // Control bundle layout, MSB first: alu_op[3:0] alu_src mem_read mem_write
  // mem_size[2:0] reg_write mem_to_reg branch jump
  localparam int CTRL_JUMP         = 0;
  localparam int CTRL_BRANCH       = 1;
  localparam int CTRL_MEM_TO_REG   = 2;
  localparam int CTRL_REG_WRITE    = 3;
  localparam int CTRL_MEM_SIZE_LSB = 4;
  localparam int CTRL_MEM_SIZE_MSB = 6;
  localparam int CTRL_MEM_WRITE    = 7;
  localparam int CTRL_MEM_READ     = 8;
  localparam int CTRL_ALU_SRC      = 9;
  localparam int CTRL_ALU_OP_LSB   = 10;
  localparam int CTRL_ALU_OP_MSB   = 13;

  localparam logic [4:0] REG_X0 = 5'd0;

  function automatic logic reads_reg(input logic uses, input logic [4:0] idx,
                                     input logic [4:0] rd);
    return uses & (idx == rd);
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// ID-stage inputs and ID/EX-stage outputs of the pipeline register, bundled
// so the ID driver (master) and the register (slave) share one port.
interface id_ex_reg_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 14,
  parameter int CNT_W  = 16
);
  logic              hold;
  logic              flush;
  logic              in_valid;
  logic [XLEN-1:0]   in_pc;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic              in_uses_rs1;
  logic              in_uses_rs2;
  logic [XLEN-1:0]   in_rs1_data;
  logic [XLEN-1:0]   in_rs2_data;
  logic [XLEN-1:0]   in_imm;
  logic [CTRL_W-1:0] in_ctrl;
  logic [4:0]        wb_rd;
  logic              wb_reg_write;
  logic              wb_valid;
  logic [XLEN-1:0]   wb_data;

  logic              id_ex_valid;
  logic [XLEN-1:0]   id_ex_pc;
  logic [XLEN-1:0]   id_ex_imm;
  logic [4:0]        id_ex_rs1;
  logic [4:0]        id_ex_rs2;
  logic [4:0]        id_ex_rd;
  logic [XLEN-1:0]   id_ex_rs1_data;
  logic [XLEN-1:0]   id_ex_rs2_data;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic              load_use_stall;
  logic              stall_if_id;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output hold, flush, in_valid, in_pc, in_rs1, in_rs2, in_rd,
           in_uses_rs1, in_uses_rs2, in_rs1_data, in_rs2_data, in_imm, in_ctrl,
           wb_rd, wb_reg_write, wb_valid, wb_data,
    input  id_ex_valid, id_ex_pc, id_ex_imm, id_ex_rs1, id_ex_rs2, id_ex_rd,
           id_ex_rs1_data, id_ex_rs2_data, id_ex_ctrl, load_use_stall,
           stall_if_id, bubble_count
  );

  modport slave (
    input  hold, flush, in_valid, in_pc, in_rs1, in_rs2, in_rd,
           in_uses_rs1, in_uses_rs2, in_rs1_data, in_rs2_data, in_imm, in_ctrl,
           wb_rd, wb_reg_write, wb_valid, wb_data,
    output id_ex_valid, id_ex_pc, id_ex_imm, id_ex_rs1, id_ex_rs2, id_ex_rd,
           id_ex_rs1_data, id_ex_rs2_data, id_ex_ctrl, load_use_stall,
           stall_if_id, bubble_count
  );
endinterface

// File: rtl/id_ex_reg_hazard_detect.sv
// Combinational load-use comparator: a load sitting in EX whose destination
// is read by the instruction currently in ID.
module hazard_detect
  import id_ex_reg_pkg::*;
(
  input  logic       i_ex_valid,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  input  logic       i_id_valid,
  input  logic       i_flush,
  input  logic       i_hold,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  output logic       o_load_use
);
  logic w_ex_is_load;
  logic w_dep;

  // Loads to x0 never produce a value worth waiting for.
  assign w_ex_is_load = i_ex_valid & i_ex_mem_read & (i_ex_rd != REG_X0);
  assign w_dep        = reads_reg(i_id_uses_rs1, i_id_rs1, i_ex_rd) |
                        reads_reg(i_id_uses_rs2, i_id_rs2, i_ex_rd);
  assign o_load_use   = w_ex_is_load & i_id_valid & ~i_flush & ~i_hold & w_dep;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating
// bubble counter. Optional writeback bypass: define ID_EX_WB_BYPASS_EN.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  id_ex_reg_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_imm;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_valid_nxt;
  logic [XLEN-1:0]   w_pc_nxt;
  logic [XLEN-1:0]   w_imm_nxt;
  logic [4:0]        w_rs1_nxt;
  logic [4:0]        w_rs2_nxt;
  logic [4:0]        w_rd_nxt;
  logic [XLEN-1:0]   w_rs1_data_nxt;
  logic [XLEN-1:0]   w_rs2_data_nxt;
  logic [CTRL_W-1:0] w_ctrl_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              w_load_use;
  logic              w_byp1;
  logic              w_byp2;
  logic [XLEN-1:0]   w_rs1_data_cap;
  logic [XLEN-1:0]   w_rs2_data_cap;

  hazard_detect u_hazard (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl[CTRL_MEM_READ]),
    .i_ex_rd       (r_rd),
    .i_id_valid    (bus.in_valid),
    .i_flush       (bus.flush),
    .i_hold        (bus.hold),
    .i_id_rs1      (bus.in_rs1),
    .i_id_rs2      (bus.in_rs2),
    .i_id_uses_rs1 (bus.in_uses_rs1),
    .i_id_uses_rs2 (bus.in_uses_rs2),
    .o_load_use    (w_load_use)
  );

`ifdef ID_EX_WB_BYPASS_EN
  // Writeback landing in the capture cycle overrides the stale regfile read.
  assign w_byp1 = bus.wb_valid & bus.wb_reg_write & (bus.wb_rd != REG_X0) &
                  (bus.wb_rd == bus.in_rs1);
  assign w_byp2 = bus.wb_valid & bus.wb_reg_write & (bus.wb_rd != REG_X0) &
                  (bus.wb_rd == bus.in_rs2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign w_rs1_data_cap = w_byp1 ? bus.wb_data : bus.in_rs1_data;
  assign w_rs2_data_cap = w_byp2 ? bus.wb_data : bus.in_rs2_data;

  // Next-state selection: hold > flush > load-use bubble > capture.
  always_comb begin
    w_valid_nxt    = r_valid;
    w_pc_nxt       = r_pc;
    w_imm_nxt      = r_imm;
    w_rs1_nxt      = r_rs1;
    w_rs2_nxt      = r_rs2;
    w_rd_nxt       = r_rd;
    w_rs1_data_nxt = r_rs1_data;
    w_rs2_data_nxt = r_rs2_data;
    w_ctrl_nxt     = r_ctrl;
    w_cnt_nxt      = r_cnt;
    if (bus.hold) begin
      w_cnt_nxt = r_cnt;
    end else if (bus.flush || w_load_use || !bus.in_valid) begin
      // Invalid ID slots are zeroed too, so no stale rd can match downstream.
      w_valid_nxt    = 1'b0;
      w_pc_nxt       = {XLEN{1'b0}};
      w_imm_nxt      = {XLEN{1'b0}};
      w_rs1_nxt      = 5'd0;
      w_rs2_nxt      = 5'd0;
      w_rd_nxt       = 5'd0;
      w_rs1_data_nxt = {XLEN{1'b0}};
      w_rs2_data_nxt = {XLEN{1'b0}};
      w_ctrl_nxt     = {CTRL_W{1'b0}};
      if (w_load_use && (r_cnt != CNT_MAX)) begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else begin
      w_valid_nxt    = 1'b1;
      w_pc_nxt       = bus.in_pc;
      w_imm_nxt      = bus.in_imm;
      w_rs1_nxt      = bus.in_rs1;
      w_rs2_nxt      = bus.in_rs2;
      w_rd_nxt       = bus.in_rd;
      w_rs1_data_nxt = w_rs1_data_cap;
      w_rs2_data_nxt = w_rs2_data_cap;
      w_ctrl_nxt     = bus.in_ctrl;
    end
  end

  // Pipeline state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= {XLEN{1'b0}};
      r_imm      <= {XLEN{1'b0}};
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_rd       <= 5'd0;
      r_rs1_data <= {XLEN{1'b0}};
      r_rs2_data <= {XLEN{1'b0}};
      r_ctrl     <= {CTRL_W{1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
    end else begin
      r_valid    <= w_valid_nxt;
      r_pc       <= w_pc_nxt;
      r_imm      <= w_imm_nxt;
      r_rs1      <= w_rs1_nxt;
      r_rs2      <= w_rs2_nxt;
      r_rd       <= w_rd_nxt;
      r_rs1_data <= w_rs1_data_nxt;
      r_rs2_data <= w_rs2_data_nxt;
      r_ctrl     <= w_ctrl_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign bus.id_ex_valid    = r_valid;
  assign bus.id_ex_pc       = r_pc;
  assign bus.id_ex_imm      = r_imm;
  assign bus.id_ex_rs1      = r_rs1;
  assign bus.id_ex_rs2      = r_rs2;
  assign bus.id_ex_rd       = r_rd;
  assign bus.id_ex_rs1_data = r_rs1_data;
  assign bus.id_ex_rs2_data = r_rs2_data;
  assign bus.id_ex_ctrl     = r_ctrl;
  assign bus.bubble_count   = r_cnt;
  assign bus.load_use_stall = w_load_use;
  assign bus.stall_if_id    = bus.hold | w_load_use;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed vector table, hand-written
// corner sequences and randomized traffic against a reference model.
module tb_id_ex_reg;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 14;
  localparam int CNT_W  = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;
  // lw: alu_src, mem_read, mem_size=010, reg_write, mem_to_reg; add: reg_write
  localparam logic [13:0] C_LW  = 14'h32C;
  localparam logic [13:0] C_ADD = 14'h008;
  localparam int MEM_READ_BIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_reg_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();
  id_ex_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the instruction currently held in EX.
  logic        m_valid;
  logic [31:0] m_pc, m_imm, m_d1, m_d2;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [13:0] m_ctrl;
  int          m_cnt;

  typedef struct {
    logic        hold, flush, v;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [13:0] ctrl;
    logic        e_stall, e_valid;
    logic [4:0]  e_rd;
    logic [31:0] e_pc;
    int          e_cnt;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic h, logic f, logic v, logic [31:0] pc,
                              logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic u1, logic u2, logic [13:0] ctrl,
                              logic es, logic ev, logic [4:0] erd,
                              logic [31:0] epc, int ecnt);
    vec_t t;
    t.hold = h; t.flush = f; t.v = v; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2;
    t.rd = rd; t.u1 = u1; t.u2 = u2; t.ctrl = ctrl; t.e_stall = es;
    t.e_valid = ev; t.e_rd = erd; t.e_pc = epc; t.e_cnt = ecnt;
    return t;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_valid = 1'b0; m_pc = 32'd0; m_imm = 32'd0; m_d1 = 32'd0; m_d2 = 32'd0;
    m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_ctrl = 14'd0;
  endtask

  function automatic bit m_stall();
    bit ex_load, dep;
    ex_load = m_valid && m_ctrl[MEM_READ_BIT] && (m_rd != 5'd0);
    dep = (bus.in_uses_rs1 && bus.in_rs1 == m_rd) ||
          (bus.in_uses_rs2 && bus.in_rs2 == m_rd);
    return ex_load && dep && bus.in_valid && !bus.flush && !bus.hold;
  endfunction

  task automatic m_update(bit s);
    if (bus.hold) return;
    if (bus.flush || s || !bus.in_valid) begin
      m_clear();
      if (s && m_cnt < CNT_SAT) m_cnt++;
    end else begin
      m_valid = 1'b1; m_pc = bus.in_pc; m_imm = bus.in_imm;
      m_rs1 = bus.in_rs1; m_rs2 = bus.in_rs2; m_rd = bus.in_rd;
      m_ctrl = bus.in_ctrl; m_d1 = bus.in_rs1_data; m_d2 = bus.in_rs2_data;
`ifdef ID_EX_WB_BYPASS_EN
      if (bus.wb_valid && bus.wb_reg_write && bus.wb_rd != 5'd0) begin
        if (bus.wb_rd == bus.in_rs1) m_d1 = bus.wb_data;
        if (bus.wb_rd == bus.in_rs2) m_d2 = bus.wb_data;
      end
`endif
    end
  endtask

  task automatic check_regs();
    check("valid", bus.id_ex_valid, m_valid);
    check("pc", bus.id_ex_pc, m_pc);
    check("imm", bus.id_ex_imm, m_imm);
    check("rs1", bus.id_ex_rs1, m_rs1);
    check("rs2", bus.id_ex_rs2, m_rs2);
    check("rd", bus.id_ex_rd, m_rd);
    check("rs1_data", bus.id_ex_rs1_data, m_d1);
    check("rs2_data", bus.id_ex_rs2_data, m_d2);
    check("ctrl", bus.id_ex_ctrl, m_ctrl);
    check("bubble_count", bus.bubble_count, m_cnt);
  endtask

  task automatic drive(logic h, logic f, logic v, logic [31:0] pc,
                       logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                       logic u1, logic u2, logic [13:0] ctrl);
    bus.hold = h; bus.flush = f; bus.in_valid = v; bus.in_pc = pc;
    bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
    bus.in_uses_rs1 = u1; bus.in_uses_rs2 = u2; bus.in_ctrl = ctrl;
    bus.in_imm = pc + 32'd4; bus.in_rs1_data = pc ^ 32'hA5A5_0000;
    bus.in_rs2_data = ~pc;
    bus.wb_valid = 1'b0; bus.wb_reg_write = 1'b0; bus.wb_rd = 5'd0;
    bus.wb_data = 32'd0;
  endtask

  // One cycle: check combinational outputs, clock, check registered outputs.
  task automatic step();
    bit s;
    #1;
    s = m_stall();
    check("load_use_stall", bus.load_use_stall, s);
    check("stall_if_id", bus.stall_if_id, bus.hold | s);
    @(posedge clk);
    m_update(s);
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 14'd0);
    m_clear();
    m_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1'b0,1'b0,1'b1,32'h100,5'd1,5'd2,5'd5,1'b1,1'b1,C_ADD, 1'b0,1'b1,5'd5,32'h100,0);
    tbl[1]  = mk(1'b0,1'b0,1'b1,32'h104,5'd2,5'd0,5'd7,1'b1,1'b0,C_LW,  1'b0,1'b1,5'd7,32'h104,0);
    tbl[2]  = mk(1'b0,1'b0,1'b1,32'h108,5'd1,5'd7,5'd8,1'b1,1'b1,C_ADD, 1'b1,1'b0,5'd0,32'h0,  1);
    tbl[3]  = mk(1'b0,1'b0,1'b1,32'h108,5'd1,5'd7,5'd8,1'b1,1'b1,C_ADD, 1'b0,1'b1,5'd8,32'h108,1);
    tbl[4]  = mk(1'b0,1'b0,1'b1,32'h10c,5'd2,5'd0,5'd7,1'b1,1'b0,C_LW,  1'b0,1'b1,5'd7,32'h10c,1);
    tbl[5]  = mk(1'b0,1'b0,1'b1,32'h110,5'd1,5'd7,5'd9,1'b1,1'b0,C_ADD, 1'b0,1'b1,5'd9,32'h110,1);
    tbl[6]  = mk(1'b0,1'b0,1'b1,32'h114,5'd2,5'd0,5'd0,1'b1,1'b0,C_LW,  1'b0,1'b1,5'd0,32'h114,1);
    tbl[7]  = mk(1'b0,1'b0,1'b1,32'h118,5'd0,5'd0,5'd10,1'b1,1'b0,C_ADD,1'b0,1'b1,5'd10,32'h118,1);
    tbl[8]  = mk(1'b0,1'b0,1'b1,32'h11c,5'd2,5'd0,5'd6,1'b1,1'b0,C_LW,  1'b0,1'b1,5'd6,32'h11c,1);
    tbl[9]  = mk(1'b1,1'b1,1'b1,32'h120,5'd6,5'd0,5'd11,1'b1,1'b0,C_ADD,1'b0,1'b1,5'd6,32'h11c,1);
    tbl[10] = tbl[9];
    tbl[11] = tbl[9];
    tbl[12] = mk(1'b0,1'b1,1'b1,32'h120,5'd6,5'd0,5'd11,1'b1,1'b0,C_ADD,1'b0,1'b0,5'd0,32'h0,  1);
    tbl[13] = mk(1'b0,1'b0,1'b1,32'h124,5'd2,5'd0,5'd6,1'b1,1'b0,C_LW,  1'b0,1'b1,5'd6,32'h124,1);
    tbl[14] = mk(1'b0,1'b1,1'b1,32'h128,5'd6,5'd0,5'd12,1'b1,1'b0,C_ADD,1'b0,1'b0,5'd0,32'h0,  1);
    tbl[15] = mk(1'b0,1'b0,1'b0,32'h200,5'd3,5'd3,5'd13,1'b1,1'b1,C_ADD,1'b0,1'b0,5'd0,32'h0,  1);

    do_reset();
    #1;
    check("reset_valid", bus.id_ex_valid, 1'b0);
    check("reset_pc", bus.id_ex_pc, 32'd0);
    check("reset_rd", bus.id_ex_rd, 5'd0);
    check("reset_ctrl", bus.id_ex_ctrl, 14'd0);
    check("reset_count", bus.bubble_count, 8'd0);
    check("reset_stall", bus.load_use_stall, 1'b0);
    @(negedge clk);

    // Directed table, checked against its own expected columns and the model.
    for (int i = 0; i < 16; i++) begin
      bit s;
      drive(tbl[i].hold, tbl[i].flush, tbl[i].v, tbl[i].pc, tbl[i].rs1,
            tbl[i].rs2, tbl[i].rd, tbl[i].u1, tbl[i].u2, tbl[i].ctrl);
      #1;
      s = m_stall();
      check($sformatf("tbl%0d_stall", i), bus.load_use_stall, tbl[i].e_stall);
      check($sformatf("tbl%0d_sif", i), bus.stall_if_id, tbl[i].hold | tbl[i].e_stall);
      @(posedge clk);
      m_update(s);
      #1;
      check($sformatf("tbl%0d_valid", i), bus.id_ex_valid, tbl[i].e_valid);
      check($sformatf("tbl%0d_rd", i), bus.id_ex_rd, tbl[i].e_rd);
      check($sformatf("tbl%0d_pc", i), bus.id_ex_pc, tbl[i].e_pc);
      check($sformatf("tbl%0d_cnt", i), bus.bubble_count, tbl[i].e_cnt);
      check_regs();
      @(negedge clk);
    end

    // Writeback in the capture cycle targeting rs1.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h300, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, C_ADD);
    bus.in_rs1_data = 32'd0;
    bus.wb_valid = 1'b1; bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd3;
    bus.wb_data = 32'hDEAD_BEEF;
    step();
`ifdef ID_EX_WB_BYPASS_EN
    check("wb_bypass_rs1", bus.id_ex_rs1_data, 32'hDEAD_BEEF);
`else
    check("no_bypass_rs1", bus.id_ex_rs1_data, 32'h0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int k;
      k = $urandom_range(0, 2);
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 4) != 0), $urandom,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            (k == 0) ? C_LW : ((k == 1) ? C_ADD : 14'($urandom)));
      bus.in_imm = $urandom; bus.in_rs1_data = $urandom; bus.in_rs2_data = $urandom;
      bus.wb_valid = 1'($urandom); bus.wb_reg_write = 1'($urandom);
      bus.wb_rd = 5'($urandom_range(0, 3)); bus.wb_data = $urandom;
      step();
    end

    // Asynchronous reset in the middle of a hold.
    drive(1'b0, 1'b0, 1'b1, 32'h400, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, C_LW);
    step();
    drive(1'b1, 1'b1, 1'b1, 32'h404, 5'd9, 5'd2, 5'd3, 1'b1, 1'b0, C_ADD);
    step();
    #2;
    rst = 1'b1;
    #1;
    m_clear();
    m_cnt = 0;
    check("arst_valid", bus.id_ex_valid, 1'b0);
    check("arst_rd", bus.id_ex_rd, 5'd0);
    check("arst_pc", bus.id_ex_pc, 32'd0);
    check_regs();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 14'd0);

    // Counter saturation: 2^CNT_W+1 load-use bubbles.
    for (int n = 0; n < CNT_SAT + 2; n++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h500, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, C_LW);
      step();
      drive(1'b0, 1'b0, 1'b1, 32'h504, 5'd7, 5'd2, 5'd8, 1'b1, 1'b1, C_ADD);
      step();
    end
    check("count_saturated", bus.bubble_count, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RISC-V core. It captures decoded instructions from ID and presents the rs1/rs2/rd, reg_write and valid fields that the EX-stage forwarding logic and operand muxes consume. It inserts a bubble and stalls IF/ID on a load-use dependency. It also keeps a saturating count of inserted bubbles.

## Interface
Parameters:
- XLEN, 32, datapath width
- CTRL_W, 14, width of packed control bundle (layout in riscv_pkg.v)
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- hold  in  1  downstream stall (memory wait); freeze ID/EX contents
- flush  in  1  branch/jump taken in EX; do not capture incoming ID instruction
- in_valid  in  1  ID holds a real instruction
- in_pc  in  XLEN  PC of ID instruction
- in_rs1, in_rs2, in_rd  in  5  register indices
- in_uses_rs1, in_uses_rs2  in  1  instruction actually reads rs1/rs2
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  decoded immediate
- in_ctrl  in  CTRL_W  packed control: alu_op[3:0], alu_src, mem_read, mem_write, mem_size[2:0], reg_write, mem_to_reg, branch, jump
- wb_rd  in  5  writeback destination
- wb_reg_write, wb_valid  in  1  writeback qualifiers
- wb_data  in  XLEN  writeback value
- id_ex_valid  out  1  registered valid
- id_ex_pc, id_ex_imm  out  XLEN  registered fields
- id_ex_rs1, id_ex_rs2, id_ex_rd  out  5  registered indices
- id_ex_rs1_data, id_ex_rs2_data  out  XLEN  registered operands
- id_ex_ctrl  out  CTRL_W  registered control bundle
- load_use_stall  out  1  combinational load-use hazard detected
- stall_if_id  out  1  combinational; equals hold | load_use_stall
- bubble_count  out  CNT_W  saturating count of load-use bubbles

## Operation
- load_use_stall = id_ex_valid & id_ex_ctrl.mem_read & (id_ex_rd != 0) & in_valid & !flush & !hold & ((in_uses_rs1 & in_rs1 == id_ex_rd) | (in_uses_rs2 & in_rs2 == id_ex_rd)).
- Update priority per edge: rst > hold > flush > load_use_stall > normal load.
  - hold: every register keeps its value; flush is ignored. The branch stays in EX and re-asserts flush after hold drops.
  - flush: load a bubble.
  - load_use_stall: load a bubble and increment bubble_count.
  - normal: capture all in_* fields; id_ex_valid <= in_valid.
- Bubble: valid, ctrl, pc, imm, rs1, rs2, rd and operand data all zero. rd=0 and ctrl.reg_write=0 guarantee no forwarding match.
- in_valid=0 under normal load is captured as-is. Fields are zeroed exactly like a bubble, so downstream sees no spurious rd.
- bubble_count saturates at all-ones and does not wrap. It does not count flush bubbles.

## Timing
- Latency: 1 cycle from ID inputs to id_ex_* outputs.
- load_use_stall and stall_if_id are combinational in the same cycle. The ID instruction is re-presented next cycle and then captured, because the load has moved to MEM.
- A load followed by a dependent instruction costs exactly 1 bubble.
- Reset (asynchronous, any cycle, including during hold): all outputs 0, bubble_count 0. The first capture occurs on the first edge after rst deasserts.
- Simultaneous flush and load_use: flush wins, load_use_stall is forced 0, and the counter does not increment.

## Configuration
- ID_EX_WB_BYPASS_EN defined: on capture, if wb_valid & wb_reg_write & wb_rd != 0 & wb_rd == in_rs1, id_ex_rs1_data <= wb_data. The same rule applies independently for rs2. This covers a same-cycle register-file write.
- Undefined: operand data is captured straight from in_rs*_data. The register file must provide write-before-read.

## Structure
- riscv_pkg.v holds the CTRL_W value, the `CTRL_*` bit-index macros for each control field, and XLEN.
- One natural sub-module: hazard_detect, the combinational load-use comparator instantiated by id_ex_reg. Everything else is flat.

## Test plan
- Normal flow: in_valid=1, rd=5, pc=0x100, reg_write=1 -> next cycle id_ex_rd=5, id_ex_pc=0x100, id_ex_valid=1, no stall.
- Load-use: ID/EX holds lw to x7; ID has add using rs2=x7 -> load_use_stall=1; next cycle bubble (valid=0, rd=0); add captured the cycle after; bubble_count=1. Same dependence with in_uses_rs2=0 -> no stall.
- Load to x0: lw rd=0 followed by a dependent instruction on x0 -> no stall, no bubble.
- Hold vs flush: hold=1 with flush=1 for 3 cycles -> outputs unchanged and stall_if_id=1. Then hold=0, flush=1 -> bubble loaded.
- Flush + load-use together -> bubble loaded, load_use_stall=0, bubble_count unchanged. Async rst mid-hold -> all outputs 0 immediately.
- With ID_EX_WB_BYPASS_EN: wb writes x3=0xDEADBEEF in the capture cycle, in_rs1=3, in_rs1_data=0 -> id_ex_rs1_data=0xDEADBEEF. Counter: force 2^CNT_W+1 load-use stalls -> bubble_count stays 0xFFFF.
